// File: rtl/reset_sequencer_if.sv
// Bundle of the sequencer's lock/request inputs and its subsystem reset outputs.
// Ports: pll_locked, soft_reset_req (into the sequencer); video_rst, game_rst,
//        audio_rst, sys_ready, seq_state (out of the sequencer).
// master = the side that supplies lock/request; slave = the sequencer itself.
interface reset_sequencer_if;
   logic       pll_locked;
   logic       soft_reset_req;
   logic       video_rst;
   logic       game_rst;
   logic       audio_rst;
   logic       sys_ready;
   logic [2:0] seq_state;

   modport master (
      output pll_locked,
      output soft_reset_req,
      input  video_rst,
      input  game_rst,
      input  audio_rst,
      input  sys_ready,
      input  seq_state
   );

   modport slave (
      input  pll_locked,
      input  soft_reset_req,
      output video_rst,
      output game_rst,
      output audio_rst,
      output sys_ready,
      output seq_state
   );
endinterface

// File: rtl/reset_sequencer.sv
// Releases video, then game, then audio resets once the PLL has been stably locked;
// supports a game-initiated soft restart that re-resets game/audio only.
// Latency: outputs are registered Moore decodes that change on the same edge as the state.
// Backpressure: none; lock loss or rst_n low forces every reset back on.
// Ports: clk, rst_n (async active-low), io (reset_sequencer_if.slave).
module reset_sequencer #(
   parameter int STAGE_DELAY = 16,
   parameter int SOFT_HOLD   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   reset_sequencer_if.slave  io
);

   localparam int MAX_DELAY = (STAGE_DELAY > SOFT_HOLD) ? STAGE_DELAY : SOFT_HOLD;
   localparam int CW        = $clog2(MAX_DELAY) + 1;

   localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
   localparam logic [CW-1:0] SOFT_LAST  = CW'(SOFT_HOLD - 1);

   typedef enum logic [2:0] {
      HOLD     = 3'd0,
      VIDEO_UP = 3'd1,
      GAME_UP  = 3'd2,
      RUN      = 3'd3,
      SOFT     = 3'd4
   } state_t;

   state_t        state;
   state_t        nxt;
   logic [CW-1:0] cnt;
   logic          video_rst_q;
   logic          game_rst_q;
   logic          audio_rst_q;
   logic          sys_ready_q;

   // Lock loss dominates everything, including a pending soft request.
   function automatic state_t next_state(input state_t        cur,
                                         input logic [CW-1:0] c,
                                         input logic          locked,
                                         input logic          req);
      state_t n;
      n = cur;
      if (!locked) begin
         n = HOLD;
      end else begin
         case (cur)
            HOLD:     if (c == STAGE_LAST) n = VIDEO_UP;
            VIDEO_UP: if (c == STAGE_LAST) n = GAME_UP;
            GAME_UP:  if (c == STAGE_LAST) n = RUN;
            RUN:      if (req)             n = SOFT;
            SOFT:     if (c == SOFT_LAST)  n = GAME_UP;
            default:                       n = HOLD;
         endcase
      end
      return n;
   endfunction

   // {video_rst, game_rst, audio_rst, sys_ready}
   function automatic logic [3:0] decode(input state_t s);
      logic [3:0] d;
      case (s)
         VIDEO_UP: d = 4'b0110;
         GAME_UP:  d = 4'b0010;
         RUN:      d = 4'b0001;
         SOFT:     d = 4'b0110;
         default:  d = 4'b1110;
      endcase
      return d;
   endfunction

   assign nxt = next_state(state, cnt, io.pll_locked, io.soft_reset_req);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HOLD;
         cnt         <= '0;
         video_rst_q <= 1'b1;
         game_rst_q  <= 1'b1;
         audio_rst_q <= 1'b1;
         sys_ready_q <= 1'b0;
      end else begin
         state <= nxt;
         // Unlocked edges restart the stable-lock count even while sitting in HOLD.
         if ((nxt != state) || !io.pll_locked) begin
            cnt <= '0;
         end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + CW'(1);
         end
         {video_rst_q, game_rst_q, audio_rst_q, sys_ready_q} <= decode(nxt);
      end
   end

   assign io.video_rst = video_rst_q;
   assign io.game_rst  = game_rst_q;
   assign io.audio_rst = audio_rst_q;
   assign io.sys_ready = sys_ready_q;
   assign io.seq_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed boot/glitch/soft/lock-loss/
// async-reset/held-request scenarios plus a randomized run, all compared against a
// timeline model (time since video release) rather than a state machine.
module tb_reset_sequencer;
   localparam int SD = 4;
   localparam int SH = 3;
   localparam logic [6:0] RST_VAL = 7'b1110_000;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   edge_no;

   reset_sequencer_if io ();

   reset_sequencer #(.STAGE_DELAY(SD), .SOFT_HOLD(SH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // booted: video is out of reset. t: edges since video release; game leaves reset
   // at t == SD, audio at t == 2*SD. A soft restart rewinds t so that game is
   // released SH edges later.
   bit m_booted;
   bit m_soft;
   int m_t;
   int m_streak;

   task automatic model_reset();
      m_booted = 1'b0;
      m_soft   = 1'b0;
      m_t      = 0;
      m_streak = 0;
   endtask

   task automatic model_edge(input bit lk, input bit rq);
      if (!m_booted) begin
         if (lk) begin
            m_streak++;
            if (m_streak == SD) begin
               m_booted = 1'b1;
               m_t      = 0;
               m_soft   = 1'b0;
            end
         end else begin
            m_streak = 0;
         end
      end else if (!lk) begin
         m_booted = 1'b0;
         m_streak = 0;
      end else if (m_t >= 2*SD && rq) begin
         m_t    = SD - SH;
         m_soft = 1'b1;
      end else begin
         m_t++;
      end
   endtask

   function automatic logic [6:0] model_outs();
      logic [2:0] s;
      if (!m_booted) return RST_VAL;
      if (m_t < SD)        s = m_soft ? 3'd4 : 3'd1;
      else if (m_t < 2*SD) s = 3'd2;
      else                 s = 3'd3;
      return {1'b0, (m_t < SD), (m_t < 2*SD), (m_t >= 2*SD), s};
   endfunction

   function automatic logic [6:0] obs();
      return {io.video_rst, io.game_rst, io.audio_rst, io.sys_ready, io.seq_state};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic step(input bit lk, input bit rq);
      io.pll_locked     = lk;
      io.soft_reset_req = rq;
      @(posedge clk);
      model_edge(lk, rq);
      edge_no++;
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n   = 1'b1;
      edge_no = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      io.pll_locked     = 1'b0;
      io.soft_reset_req = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      model_reset();
      #12;
      n_checks++;
      if (obs() !== RST_VAL) begin
         n_fail++;
         $display("FAIL reset_values: got %b want %b", obs(), RST_VAL);
      end
   endtask

   task automatic test_boot();
      int v_fall, g_fall, a_fall, r_rise;
      logic [2:0] seq_at [4];
      v_fall = -1; g_fall = -1; a_fall = -1; r_rise = -1;
      io.pll_locked = 1'b1;
      @(negedge clk);
      rst_n   = 1'b1;
      edge_no = 0;
      for (int e = 1; e <= 14; e++) begin
         step(1'b1, 1'b0);
         n_checks++;
         if (obs() !== model_outs()) begin
            n_fail++;
            $display("FAIL boot_model edge %0d: got %b want %b", edge_no, obs(), model_outs());
         end
         if (!io.video_rst && v_fall < 0) v_fall = edge_no;
         if (!io.game_rst  && g_fall < 0) g_fall = edge_no;
         if (!io.audio_rst && a_fall < 0) a_fall = edge_no;
         if (io.sys_ready  && r_rise < 0) r_rise = edge_no;
         if (edge_no == 3)  seq_at[0] = io.seq_state;
         if (edge_no == 4)  seq_at[1] = io.seq_state;
         if (edge_no == 8)  seq_at[2] = io.seq_state;
         if (edge_no == 12) seq_at[3] = io.seq_state;
      end
      n_checks += 4;
      if (v_fall != SD)   begin n_fail++; $display("FAIL boot_video_edge: got %0d want %0d", v_fall, SD);   end
      if (g_fall != 2*SD) begin n_fail++; $display("FAIL boot_game_edge: got %0d want %0d", g_fall, 2*SD);  end
      if (a_fall != 3*SD) begin n_fail++; $display("FAIL boot_audio_edge: got %0d want %0d", a_fall, 3*SD); end
      if (r_rise != 3*SD) begin n_fail++; $display("FAIL boot_ready_edge: got %0d want %0d", r_rise, 3*SD); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (seq_at[i] !== 3'(i)) begin
            n_fail++;
            $display("FAIL boot_seq_step %0d: got %0d want %0d", i, seq_at[i], i);
         end
      end
   endtask

   task automatic test_lock_glitch();
      bit pat [10] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
      int v_fall;
      v_fall = -1;
      io.pll_locked = 1'b0;
      apply_reset();
      for (int e = 0; e < 10; e++) begin
         step(pat[e], 1'b0);
         n_checks++;
         if (obs() !== model_outs()) begin
            n_fail++;
            $display("FAIL glitch_model edge %0d: got %b want %b", edge_no, obs(), model_outs());
         end
         if (!io.video_rst && v_fall < 0) v_fall = edge_no;
      end
      n_checks++;
      if (v_fall != 3 + SD) begin
         n_fail++;
         $display("FAIL glitch_video_edge: got %0d want %0d", v_fall, 3 + SD);
      end
   endtask

   task automatic test_soft();
      int  g_fall, a_fall, r_rise, budget;
      bit  video_seen;
      g_fall = -1; a_fall = -1; r_rise = -1; video_seen = 1'b0;
      budget = 0;
      while (!io.sys_ready && budget < 40) begin
         step(1'b1, 1'b0);
         budget++;
      end
      n_checks++;
      if (!io.sys_ready) begin
         n_fail++;
         $display("FAIL soft_reach_run: got sys_ready %b want 1", io.sys_ready);
      end
      step(1'b1, 1'b1);
      n_checks++;
      if (obs() !== 7'b0110_100) begin
         n_fail++;
         $display("FAIL soft_entry: got %b want %b", obs(), 7'b0110_100);
      end
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 1'b0);
         n_checks++;
         if (obs() !== model_outs()) begin
            n_fail++;
            $display("FAIL soft_model +%0d: got %b want %b", k, obs(), model_outs());
         end
         if (io.video_rst) video_seen = 1'b1;
         if (!io.game_rst  && g_fall < 0) g_fall = k;
         if (!io.audio_rst && a_fall < 0) a_fall = k;
         if (io.sys_ready  && r_rise < 0) r_rise = k;
      end
      n_checks += 4;
      if (g_fall != SH)      begin n_fail++; $display("FAIL soft_game_fall: got %0d want %0d", g_fall, SH);       end
      if (a_fall != SH + SD) begin n_fail++; $display("FAIL soft_audio_fall: got %0d want %0d", a_fall, SH + SD); end
      if (r_rise != SH + SD) begin n_fail++; $display("FAIL soft_ready_rise: got %0d want %0d", r_rise, SH + SD); end
      if (video_seen)        begin n_fail++; $display("FAIL soft_video_kept: got video_rst 1 want 0");            end
   endtask

   task automatic test_lock_loss_soft();
      int r_rise;
      r_rise = -1;
      step(1'b1, 1'b1);
      n_checks++;
      if (io.seq_state !== 3'd4) begin
         n_fail++;
         $display("FAIL lockloss_in_soft: got %0d want 4", io.seq_state);
      end
      step(1'b0, 1'b1);
      n_checks++;
      if (obs() !== RST_VAL) begin
         n_fail++;
         $display("FAIL lockloss_hold: got %b want %b", obs(), RST_VAL);
      end
      for (int e = 1; e <= 14; e++) begin
         step(1'b1, 1'b0);
         n_checks++;
         if (obs() !== model_outs()) begin
            n_fail++;
            $display("FAIL lockloss_reboot_model +%0d: got %b want %b", e, obs(), model_outs());
         end
         if (io.sys_ready && r_rise < 0) r_rise = e;
      end
      n_checks++;
      if (r_rise != 3*SD) begin
         n_fail++;
         $display("FAIL lockloss_reboot_ready: got %0d want %0d", r_rise, 3*SD);
      end
   endtask

   task automatic test_async_reset();
      int v_fall, r_rise;
      v_fall = -1; r_rise = -1;
      io.pll_locked = 1'b1;
      apply_reset();
      for (int e = 0; e < 2*SD + 1; e++) step(1'b1, 1'b0);
      n_checks++;
      if (io.seq_state !== 3'd2) begin
         n_fail++;
         $display("FAIL async_pre_state: got %0d want 2", io.seq_state);
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (obs() !== RST_VAL) begin
         n_fail++;
         $display("FAIL async_no_edge: got %b want %b", obs(), RST_VAL);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      edge_no = 0;
      for (int e = 1; e <= 13; e++) begin
         step(1'b1, 1'b0);
         n_checks++;
         if (obs() !== model_outs()) begin
            n_fail++;
            $display("FAIL async_reboot_model edge %0d: got %b want %b", edge_no, obs(), model_outs());
         end
         if (!io.video_rst && v_fall < 0) v_fall = edge_no;
         if (io.sys_ready  && r_rise < 0) r_rise = edge_no;
      end
      n_checks += 2;
      if (v_fall != SD)   begin n_fail++; $display("FAIL async_video_edge: got %0d want %0d", v_fall, SD);   end
      if (r_rise != 3*SD) begin n_fail++; $display("FAIL async_ready_edge: got %0d want %0d", r_rise, 3*SD); end
   endtask

   task automatic test_req_held();
      int  first_rise, last_rise, rises, long_runs;
      bit  prev;
      first_rise = -1; last_rise = -1; rises = 0; long_runs = 0; prev = 1'b0;
      io.pll_locked     = 1'b1;
      io.soft_reset_req = 1'b1;
      apply_reset();
      for (int e = 1; e <= 60; e++) begin
         step(1'b1, 1'b1);
         n_checks++;
         if (obs() !== model_outs()) begin
            n_fail++;
            $display("FAIL held_model edge %0d: got %b want %b", edge_no, obs(), model_outs());
         end
         if (io.sys_ready && !prev) begin
            rises++;
            if (first_rise < 0) first_rise = edge_no;
            last_rise = edge_no;
         end
         if (io.sys_ready && prev) long_runs++;
         prev = io.sys_ready;
      end
      n_checks += 4;
      if (first_rise != 3*SD) begin n_fail++; $display("FAIL held_first_run: got %0d want %0d", first_rise, 3*SD); end
      if (rises != 7)         begin n_fail++; $display("FAIL held_loop_count: got %0d want 7", rises);             end
      if (long_runs != 0)     begin n_fail++; $display("FAIL held_run_width: got %0d extra cycles want 0", long_runs); end
      if (last_rise - first_rise != 6*(1 + SH + SD)) begin
         n_fail++;
         $display("FAIL held_loop_period: got %0d want %0d", last_rise - first_rise, 6*(1 + SH + SD));
      end
      io.soft_reset_req = 1'b0;
   endtask

   task automatic test_random();
      bit lk, rq;
      io.pll_locked = 1'b1;
      apply_reset();
      for (int e = 0; e < 1500; e++) begin
         lk = ($urandom_range(0, 39) != 0);
         rq = ($urandom_range(0, 5) == 0);
         step(lk, rq);
         n_checks++;
         if (obs() !== model_outs()) begin
            n_fail++;
            $display("FAIL random_model edge %0d: got %b want %b", edge_no, obs(), model_outs());
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      edge_no  = 0;
      model_reset();
      test_reset();
      test_boot();
      test_lock_glitch();
      test_soft();
      test_lock_loss_soft();
      test_async_reset();
      test_req_held();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
